// File: rtl/beer_slot_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// beer_slot_scheduler_pkg
// Shared types and default geometry for the sliding-beer slot scheduler.
//   state_t      : scheduler FSM state (S_IDLE, S_SCAN)
//   DEF_*        : default slot count, field widths and screen geometry
//   CNT_W        : width of the catch/miss score counters
//   sat_inc      : saturating +1 for the score counters
// ---------------------------------------------------------------------------
package beer_slot_scheduler_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_t;

  localparam int DEF_NUM_SLOTS = 4;
  localparam int DEF_LANE_W    = 2;
  localparam int DEF_X_W       = 10;
  localparam int X_START       = 40;
  localparam int X_END         = 600;
  localparam int CATCH_X       = 560;
  localparam int STEP          = 4;
  localparam int MAX_MISS      = 3;

  localparam int CNT_W         = 8;

  // Score counters stick at all-ones instead of wrapping back to zero.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/beer_slot_scheduler_if.sv
// ---------------------------------------------------------------------------
// beer_slot_scheduler_if
// Bundles the game-side controls and the sprite-side slot bus of the
// scheduler.
//   master : game logic / sprite side (drives tick, serve_req, serve_lane,
//            p2_lane; observes everything else)
//   slave  : the scheduler itself
// Slot i occupies slot_lane[i*LANE_W +: LANE_W] and slot_x[i*X_W +: X_W].
// ---------------------------------------------------------------------------
interface beer_slot_scheduler_if #(
  parameter int NUM_SLOTS = 4,
  parameter int LANE_W    = 2,
  parameter int X_W       = 10
) ();

  logic                        tick;
  logic                        serve_req;
  logic [LANE_W-1:0]           serve_lane;
  logic [LANE_W-1:0]           p2_lane;
  logic                        serve_ack;
  logic                        busy;
  logic [NUM_SLOTS-1:0]        slot_valid;
  logic [NUM_SLOTS*LANE_W-1:0] slot_lane;
  logic [NUM_SLOTS*X_W-1:0]    slot_x;
  logic                        catch_pulse;
  logic                        miss_pulse;
  logic [7:0]                  catch_cnt;
  logic [7:0]                  miss_cnt;
  logic                        game_over;

  modport master (
    output tick, serve_req, serve_lane, p2_lane,
    input  serve_ack, busy, slot_valid, slot_lane, slot_x,
           catch_pulse, miss_pulse, catch_cnt, miss_cnt, game_over
  );

  modport slave (
    input  tick, serve_req, serve_lane, p2_lane,
    output serve_ack, busy, slot_valid, slot_lane, slot_x,
           catch_pulse, miss_pulse, catch_cnt, miss_cnt, game_over
  );

endinterface

// File: rtl/beer_slot_scheduler_free_slot_finder.sv
// ---------------------------------------------------------------------------
// beer_slot_scheduler_free_slot_finder
// Priority encoder over the free-slot vector: returns the lowest free index.
//   free_i     : bit i set when slot i is not live
//   idx_o      : lowest set index of free_i (0 when none is set)
//   any_free_o : at least one slot is free
// ---------------------------------------------------------------------------
module beer_slot_scheduler_free_slot_finder #(
  parameter int NUM_SLOTS = 4,
  parameter int IDX_W     = 2
) (
  input  logic [NUM_SLOTS-1:0] free_i,
  output logic [IDX_W-1:0]     idx_o,
  output logic                 any_free_o
);

  // Scan downwards so the last (lowest) hit wins.
  always_comb begin
    idx_o      = '0;
    any_free_o = |free_i;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (free_i[i]) idx_o = IDX_W'(i);
    end
  end

endmodule

// File: rtl/beer_slot_scheduler.sv
// ---------------------------------------------------------------------------
// beer_slot_scheduler
// Owns the sliding mugs: allocates a slot per P1 serve keypress, walks every
// slot once per game tick (one slot per clock), retires mugs caught by P2 or
// lost at the bar end, and keeps the catch/miss score plus game-over flag.
//   CLK100MHZ : system clock
//   RESET     : synchronous active-high reset (also aborts a running scan)
//   bus       : slave side of beer_slot_scheduler_if
//               in : tick, serve_req, serve_lane, p2_lane
//               out: serve_ack, busy, slot_valid/lane/x, catch/miss pulses,
//                    catch_cnt, miss_cnt, game_over
// ---------------------------------------------------------------------------
module beer_slot_scheduler
  import beer_slot_scheduler_pkg::*;
#(
  parameter int NUM_SLOTS = DEF_NUM_SLOTS,
  parameter int LANE_W    = DEF_LANE_W,
  parameter int X_W       = DEF_X_W
) (
  input  logic                  CLK100MHZ,
  input  logic                  RESET,
  beer_slot_scheduler_if.slave  bus
);

  localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_SLOTS - 1);
  localparam logic [X_W-1:0]   X_START_C  = X_W'(X_START);
  // Position math is one bit wider than X so a mug near the right edge
  // cannot wrap back to a small x.
  localparam logic [X_W:0]     STEP_C     = (X_W + 1)'(STEP);
  localparam logic [X_W:0]     X_END_C    = (X_W + 1)'(X_END);
  localparam logic [X_W:0]     CATCH_X_C  = (X_W + 1)'(CATCH_X);
  localparam logic [CNT_W-1:0] MAX_MISS_C = CNT_W'(MAX_MISS);

  // FSM and control state
  state_t               state_q;
  logic [IDX_W-1:0]     idx_q;
  logic                 tick_pending_q;
  logic                 armed_q;

  // Slot storage
  logic                 valid_q [NUM_SLOTS];
  logic [LANE_W-1:0]    lane_q  [NUM_SLOTS];
  logic [X_W-1:0]       x_q     [NUM_SLOTS];

  // Registered outputs
  logic                 serve_ack_q;
  logic                 catch_q;
  logic                 miss_q;
  logic [CNT_W-1:0]     catch_cnt_q;
  logic [CNT_W-1:0]     miss_cnt_q;
  logic                 game_over_q;

  // Combinational next-state helpers
  logic [NUM_SLOTS-1:0] free_vec_d;
  logic [IDX_W-1:0]     free_idx_d;
  logic                 any_free_d;
  logic [X_W:0]         scan_nx_d;
  logic                 scan_catch_d;
  logic                 scan_miss_d;
  logic                 serve_ok_d;
  logic                 rescan_d;
  logic [CNT_W-1:0]     miss_cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot_io
      assign free_vec_d[gi]                         = ~valid_q[gi];
      assign bus.slot_valid[gi]                     = valid_q[gi];
      assign bus.slot_lane[gi*LANE_W +: LANE_W]     = lane_q[gi];
      assign bus.slot_x[gi*X_W +: X_W]              = x_q[gi];
    end
  endgenerate

  beer_slot_scheduler_free_slot_finder #(
    .NUM_SLOTS (NUM_SLOTS),
    .IDX_W     (IDX_W)
  ) u_free_slot_finder (
    .free_i     (free_vec_d),
    .idx_o      (free_idx_d),
    .any_free_o (any_free_d)
  );

  // Evaluation of the slot currently addressed by the scan pointer. Catch is
  // tested first so a mug in P2's lane past CATCH_X never counts as a miss.
  always_comb begin
    scan_nx_d    = {1'b0, x_q[idx_q]} + STEP_C;
    scan_catch_d = valid_q[idx_q] && (lane_q[idx_q] == bus.p2_lane) &&
                   (scan_nx_d >= CATCH_X_C);
    scan_miss_d  = valid_q[idx_q] && !scan_catch_d && (scan_nx_d >= X_END_C);
    miss_cnt_d   = sat_inc(miss_cnt_q);
  end

  // A serve only lands on a quiet IDLE cycle; any tick (new or queued) wins.
  assign serve_ok_d = (state_q == S_IDLE) && !bus.tick && !tick_pending_q &&
                      !game_over_q && any_free_d && bus.serve_req && armed_q;

  // A tick seen on or before the last scan cycle chains straight into the
  // next pass so busy never drops between the two scans.
  assign rescan_d = tick_pending_q || bus.tick;

  always_ff @(posedge CLK100MHZ) begin
    if (RESET) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      tick_pending_q <= 1'b0;
      armed_q        <= 1'b0;
      serve_ack_q    <= 1'b0;
      catch_q        <= 1'b0;
      miss_q         <= 1'b0;
      catch_cnt_q    <= '0;
      miss_cnt_q     <= '0;
      game_over_q    <= 1'b0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        valid_q[i] <= 1'b0;
        lane_q[i]  <= '0;
        x_q[i]     <= '0;
      end
    end else begin
      serve_ack_q <= 1'b0;
      catch_q     <= 1'b0;
      miss_q      <= 1'b0;

      // Releasing the key re-arms serving: one mug per keypress.
      if (!bus.serve_req) armed_q <= 1'b1;

      case (state_q)
        S_IDLE: begin
          if (bus.tick || tick_pending_q) begin
            state_q        <= S_SCAN;
            idx_q          <= '0;
            tick_pending_q <= 1'b0;
          end else if (serve_ok_d) begin
            valid_q[free_idx_d] <= 1'b1;
            lane_q[free_idx_d]  <= bus.serve_lane;
            x_q[free_idx_d]     <= X_START_C;
            serve_ack_q         <= 1'b1;
            armed_q             <= 1'b0;
          end
        end

        S_SCAN: begin
          if (bus.tick) tick_pending_q <= 1'b1;

          if (scan_catch_d) begin
            valid_q[idx_q] <= 1'b0;
            catch_q        <= 1'b1;
            catch_cnt_q    <= sat_inc(catch_cnt_q);
          end else if (scan_miss_d) begin
            valid_q[idx_q] <= 1'b0;
            miss_q         <= 1'b1;
            miss_cnt_q     <= miss_cnt_d;
            if (miss_cnt_d >= MAX_MISS_C) game_over_q <= 1'b1;
          end else if (valid_q[idx_q]) begin
            x_q[idx_q] <= scan_nx_d[X_W-1:0];
          end

          if (idx_q == LAST_IDX) begin
            idx_q <= '0;
            if (rescan_d) begin
              tick_pending_q <= 1'b0;
            end else begin
              state_q <= S_IDLE;
            end
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end

        default: begin
          state_q <= S_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  assign bus.busy        = (state_q == S_SCAN);
  assign bus.serve_ack   = serve_ack_q;
  assign bus.catch_pulse = catch_q;
  assign bus.miss_pulse  = miss_q;
  assign bus.catch_cnt   = catch_cnt_q;
  assign bus.miss_cnt    = miss_cnt_q;
  assign bus.game_over   = game_over_q;

endmodule

// File: tb/tb_beer_slot_scheduler.sv
// ---------------------------------------------------------------------------
// tb_beer_slot_scheduler
// Self-checking bench for beer_slot_scheduler: a table of serve presses, a
// behavioural slot model that queues the expected ack/catch/miss events, a
// monitor that pops and compares them as the DUT emits them, and hand-written
// sequences for chained ticks, long slides, game over and reset mid-scan.
// ---------------------------------------------------------------------------
module tb_beer_slot_scheduler;
  import beer_slot_scheduler_pkg::*;

  localparam int NS = 4;
  localparam int LW = 2;
  localparam int XW = 10;

  logic CLK100MHZ = 1'b0;
  logic RESET;

  always #5 CLK100MHZ = ~CLK100MHZ;

  beer_slot_scheduler_if #(.NUM_SLOTS(NS), .LANE_W(LW), .X_W(XW)) bus ();

  beer_slot_scheduler #(.NUM_SLOTS(NS), .LANE_W(LW), .X_W(XW)) dut (
    .CLK100MHZ (CLK100MHZ),
    .RESET     (RESET),
    .bus       (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // kind: 0 = serve ack, 1 = catch, 2 = miss
  typedef struct {
    int kind;
    int slot;
    int lane;
  } ev_t;
  ev_t sb_q[$];

  // Behavioural model of the slot table
  bit m_valid [NS];
  int m_lane  [NS];
  int m_x     [NS];
  int m_catch;
  int m_miss;
  bit m_go;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NS; i++) begin
      m_valid[i] = 1'b0;
      m_lane[i]  = 0;
      m_x[i]     = 0;
    end
    m_catch = 0;
    m_miss  = 0;
    m_go    = 1'b0;
    sb_q.delete();
  endfunction

  function automatic int model_free();
    for (int i = 0; i < NS; i++) if (!m_valid[i]) return i;
    return -1;
  endfunction

  function automatic void model_serve(input int lane);
    int s;
    ev_t e;
    s = model_free();
    m_valid[s] = 1'b1;
    m_lane[s]  = lane;
    m_x[s]     = 40;
    e.kind = 0; e.slot = s; e.lane = lane;
    sb_q.push_back(e);
  endfunction

  function automatic void model_tick(input int p2);
    int nx;
    ev_t e;
    for (int i = 0; i < NS; i++) begin
      if (m_valid[i]) begin
        nx = m_x[i] + 4;
        e.slot = i; e.lane = m_lane[i];
        if (m_lane[i] == p2 && nx >= 560) begin
          m_valid[i] = 1'b0;
          if (m_catch < 255) m_catch++;
          e.kind = 1;
          sb_q.push_back(e);
        end else if (nx >= 600) begin
          m_valid[i] = 1'b0;
          if (m_miss < 255) m_miss++;
          if (m_miss >= 3) m_go = 1'b1;
          e.kind = 2;
          sb_q.push_back(e);
        end else begin
          m_x[i] = nx;
        end
      end
    end
  endfunction

  task automatic step();
    @(posedge CLK100MHZ);
    #1;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (bus.busy && n < 100) begin
      step();
      n++;
    end
    if (bus.busy) begin
      n_cmp++;
      n_fail++;
      $display("FAIL scan_timeout: busy still 1 after %0d cycles, required 0", n);
    end
  endtask

  task automatic do_tick(input int p2);
    bus.p2_lane = LW'(p2);
    bus.tick    = 1'b1;
    model_tick(p2);
    step();
    bus.tick = 1'b0;
    wait_idle();
  endtask

  // Event monitor: every ack/catch/miss the DUT emits must match the
  // oldest expectation queued by the model.
  always @(posedge CLK100MHZ) begin
    ev_t e;
    int  act_kind;
    #1;
    if (!RESET && (bus.serve_ack || bus.catch_pulse || bus.miss_pulse)) begin
      act_kind = bus.serve_ack ? 0 : (bus.catch_pulse ? 1 : 2);
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d, required no event", act_kind);
      end else begin
        e = sb_q.pop_front();
        check("event_kind", 64'(act_kind), 64'(e.kind));
        check("event_slot_valid", 64'(bus.slot_valid[e.slot]), 64'(e.kind == 0));
        if (e.kind == 0) check("ack_lane", 64'(bus.slot_lane[e.slot*LW +: LW]), 64'(e.lane));
        $display("event kind=%0d slot=%0d pending=%0d", act_kind, e.slot, sb_q.size());
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required $finish earlier");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int         lane;
    int         hold;
    int         exp_acks;
    logic [3:0] exp_mask;
  } vec_t;
  vec_t vecs [5];

  initial begin
    int acks;
    int busy_cnt;

    // Press table: a long hold yields only one mug; the fifth press finds
    // every slot taken and is ignored.
    vecs[0] = '{lane: 0, hold: 5, exp_acks: 1, exp_mask: 4'b0001};
    vecs[1] = '{lane: 1, hold: 1, exp_acks: 1, exp_mask: 4'b0011};
    vecs[2] = '{lane: 2, hold: 1, exp_acks: 1, exp_mask: 4'b0111};
    vecs[3] = '{lane: 3, hold: 2, exp_acks: 1, exp_mask: 4'b1111};
    vecs[4] = '{lane: 1, hold: 3, exp_acks: 0, exp_mask: 4'b1111};

    model_reset();
    RESET          = 1'b1;
    bus.tick       = 1'b0;
    bus.serve_req  = 1'b0;
    bus.serve_lane = '0;
    bus.p2_lane    = '0;
    repeat (3) step();
    check("rst_valid", 64'(bus.slot_valid), 0);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_ack", 64'(bus.serve_ack), 0);
    check("rst_cnts", 64'({bus.catch_cnt, bus.miss_cnt}), 0);
    check("rst_game_over", 64'(bus.game_over), 0);
    check("rst_x", 64'(bus.slot_x), 0);
    RESET = 1'b0;
    step();

    for (int v = 0; v < 5; v++) begin
      bus.serve_lane = LW'(vecs[v].lane);
      bus.serve_req  = 1'b1;
      if (model_free() >= 0 && !m_go) model_serve(vecs[v].lane);
      acks = 0;
      for (int h = 0; h < vecs[v].hold; h++) begin
        step();
        acks += int'(bus.serve_ack);
      end
      bus.serve_req = 1'b0;
      step();
      check("tbl_acks", 64'(acks), 64'(vecs[v].exp_acks));
      check("tbl_mask", 64'(bus.slot_valid), 64'(vecs[v].exp_mask));
      $display("press %0d lane=%0d acks=%0d mask=%b", v, vecs[v].lane, acks, bus.slot_valid);
    end
    for (int i = 0; i < NS; i++) check("served_x", 64'(bus.slot_x[i*XW +: XW]), 40);

    // Fifth request stays held from here on; it must wait for a free slot.
    bus.serve_lane = 2'd1;
    bus.serve_req  = 1'b1;
    step();
    step();

    // Ticks during a scan: one extra pass, extras dropped, busy 8 cycles.
    bus.p2_lane = 2'd1;
    bus.tick    = 1'b1;
    model_tick(1);
    step();
    busy_cnt = 0;
    for (int k = 0; k < 40 && bus.busy; k++) begin
      busy_cnt++;
      bus.tick = (k == 1 || k == 2);
      if (k == 1) model_tick(1);
      step();
    end
    bus.tick = 1'b0;
    check("chained_busy_cycles", 64'(busy_cnt), 8);
    for (int i = 0; i < NS; i++) check("chained_x", 64'(bus.slot_x[i*XW +: XW]), 48);
    $display("chained scan busy_cnt=%0d", busy_cnt);

    // Long slide: slot 1 (P2's lane) caught, held request then lands,
    // the other three drop off the bar end and end the game.
    for (int t = 0; t < 140; t++) begin
      do_tick(1);
      if (t == 127) begin
        check("catch_cnt_at_catch", 64'(bus.catch_cnt), 1);
        check("miss_cnt_at_catch", 64'(bus.miss_cnt), 0);
      end
      if (!m_go && model_free() >= 0 && t == 127) model_serve(1);
      step();
      step();
    end
    check("catch_cnt", 64'(bus.catch_cnt), 1);
    check("miss_cnt", 64'(bus.miss_cnt), 3);
    check("game_over", 64'(bus.game_over), 1);
    check("after_go_mask", 64'(bus.slot_valid), 4'b0010);
    check("late_mug_x", 64'(bus.slot_x[1*XW +: XW]), 88);
    check("model_cnts", 64'({bus.catch_cnt, bus.miss_cnt}), 64'({8'(m_catch), 8'(m_miss)}));
    $display("long slide catch=%0d miss=%0d go=%0b", bus.catch_cnt, bus.miss_cnt, bus.game_over);

    // Fresh keypress after game over: never acknowledged.
    bus.serve_req = 1'b0;
    step();
    bus.serve_req = 1'b1;
    acks = 0;
    repeat (4) begin
      step();
      acks += int'(bus.serve_ack);
    end
    bus.serve_req = 1'b0;
    step();
    check("go_blocks_serve", 64'(acks), 0);
    check("go_mask", 64'(bus.slot_valid), 4'b0010);

    // Reset while the scan pointer sits on slot 2.
    bus.tick = 1'b1;
    step();
    bus.tick = 1'b0;
    step();
    step();
    check("mid_scan_busy", 64'(bus.busy), 1);
    RESET = 1'b1;
    step();
    check("mid_rst_valid", 64'(bus.slot_valid), 0);
    check("mid_rst_busy", 64'(bus.busy), 0);
    check("mid_rst_cnts", 64'({bus.catch_cnt, bus.miss_cnt}), 0);
    check("mid_rst_game_over", 64'(bus.game_over), 0);
    RESET = 1'b0;
    model_reset();
    step();
    $display("reset mid-scan done");

    // Single mug in lane 2 with P2 elsewhere: lost exactly on tick 140.
    bus.serve_lane = 2'd2;
    bus.serve_req  = 1'b1;
    model_serve(2);
    step();
    bus.serve_req = 1'b0;
    step();
    for (int t = 0; t < 139; t++) begin
      do_tick(0);
      step();
    end
    check("pre_miss_valid", 64'(bus.slot_valid), 4'b0001);
    check("pre_miss_x", 64'(bus.slot_x[0 +: XW]), 596);
    check("pre_miss_cnt", 64'(bus.miss_cnt), 0);
    do_tick(0);
    step();
    check("miss_valid", 64'(bus.slot_valid), 0);
    check("miss_cnt_one", 64'(bus.miss_cnt), 1);
    check("miss_no_go", 64'(bus.game_over), 0);
    $display("single mug miss_cnt=%0d", bus.miss_cnt);

    // Tick and serve on the same IDLE cycle: the tick wins, serve follows.
    bus.serve_lane = 2'd3;
    bus.serve_req  = 1'b1;
    bus.tick       = 1'b1;
    model_tick(0);
    step();
    bus.tick = 1'b0;
    check("tick_wins_busy", 64'(bus.busy), 1);
    check("tick_wins_no_ack", 64'(bus.serve_ack), 0);
    wait_idle();
    model_serve(3);
    step();
    check("serve_after_scan_ack", 64'(bus.serve_ack), 1);
    bus.serve_req = 1'b0;
    step();
    step();

    check("scoreboard_drained", 64'(sb_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
